// File: rtl/mac_operand_loader.sv
// Operand loader for the 256x256 shift-add MAC: packs a narrow word stream into
// a two-entry ping-pong buffer and presents each A/B pair for one full MAC period.
module mac_operand_loader #(
  parameter int WORD_W     = 32,
  parameter int OP_W       = 256,
  parameter int MAC_PERIOD = 259,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [OP_W-1:0]   op_a,
  output logic [OP_W-1:0]   op_b,
  output logic              mac_en,
  output logic              pair_done,
  output logic              busy,
  output logic [CNT_W-1:0]  pairs_done
);

  localparam int WPP   = 2 * OP_W / WORD_W;
  localparam int HALF  = WPP / 2;
  localparam int IDX_W = (WPP > 1) ? $clog2(WPP) : 1;
  localparam int PER_W = (MAC_PERIOD > 1) ? $clog2(MAC_PERIOD) : 1;

  localparam logic [IDX_W-1:0] LAST_WORD  = IDX_W'(WPP - 1);
  localparam logic [PER_W-1:0] LAST_CYCLE = PER_W'(MAC_PERIOD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [PER_W-1:0]  cyc_reg, cyc_next;
  logic [1:0]        full_reg, full_next;
  logic              wr_ptr_reg, wr_ptr_next;
  logic              rd_ptr_reg, rd_ptr_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [CNT_W-1:0]  pairs_reg, pairs_next;

  logic [WORD_W-1:0] mem [2][WPP];

  logic xfer;
  logic last_word;
  logic period_end;
  logic release_pair;

  // Handshake readiness depends only on registered flags, never on in_valid.
  assign in_ready     = ~full_reg[wr_ptr_reg];
  assign xfer         = in_valid & in_ready & ~clear;
  assign last_word    = xfer && (idx_reg == LAST_WORD);
  assign period_end   = (state_reg == RUN) && (cyc_reg == LAST_CYCLE);
  assign release_pair = period_end & ~clear;

  // Word storage; a full buffer is never written, so the presented pair is stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < WPP; w++) begin
          mem[b][w] <= '0;
        end
      end
    end else if (xfer) begin
      mem[wr_ptr_reg][idx_reg] <= in_data;
    end
  end

  // Fill/drain bookkeeping: flags, pointers, word index, completed-pair count.
  always_comb begin
    idx_next    = idx_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    full_next   = full_reg;
    pairs_next  = pairs_reg;
    if (clear) begin
      idx_next    = '0;
      wr_ptr_next = 1'b0;
      rd_ptr_next = 1'b0;
      full_next   = '0;
    end else begin
      if (xfer) begin
        if (last_word) begin
          idx_next              = '0;
          full_next[wr_ptr_reg] = 1'b1;
          wr_ptr_next           = ~wr_ptr_reg;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      if (release_pair) begin
        full_next[rd_ptr_reg] = 1'b0;
        rd_ptr_next           = ~rd_ptr_reg;
        pairs_next            = pairs_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg    <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      full_reg   <= '0;
      pairs_reg  <= '0;
    end else begin
      idx_reg    <= idx_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      full_reg   <= full_next;
      pairs_reg  <= pairs_next;
    end
  end

  // Presentation FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cyc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
    end
  end

  // Presentation FSM: next state. Flags are the registered values, so a pair
  // completing on the release edge is picked up one cycle later.
  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    if (clear) begin
      state_next = IDLE;
      cyc_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cyc_next = '0;
          if (full_reg[rd_ptr_reg]) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (period_end) begin
            cyc_next   = '0;
            state_next = full_reg[~rd_ptr_reg] ? RUN : IDLE;
          end else begin
            cyc_next = cyc_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cyc_next   = '0;
        end
      endcase
    end
  end

  // Presentation FSM: outputs.
  always_comb begin
    mac_en    = (state_reg == RUN);
    pair_done = release_pair;
    busy      = (state_reg == RUN) | (|full_reg) | (idx_reg != '0);
  end

  assign pairs_done = pairs_reg;

  // Operands come straight from the buffer selected by the read pointer.
  for (genvar gi = 0; gi < HALF; gi++) begin : g_ops
    assign op_a[gi*WORD_W +: WORD_W] = mem[rd_ptr_reg][gi];
    assign op_b[gi*WORD_W +: WORD_W] = mem[rd_ptr_reg][HALF + gi];
  end

endmodule

// File: tb/tb_mac_operand_loader.sv
// Directed bench for mac_operand_loader: single pair, back-to-back, backpressure,
// bubble, clear and asynchronous reset, with hand-computed expectations.
module tb_mac_operand_loader;

  localparam int WORD_W = 32;
  localparam int OP_W   = 256;
  localparam int PERIOD = 259;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic              mac_en;
  logic              pair_done;
  logic              busy;
  logic [CNT_W-1:0]  pairs_done;

  int tests = 0;
  int fails = 0;

  mac_operand_loader #(
    .WORD_W(WORD_W), .OP_W(OP_W), .MAC_PERIOD(PERIOD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .op_a(op_a), .op_b(op_b),
    .mac_en(mac_en), .pair_done(pair_done), .busy(busy), .pairs_done(pairs_done)
  );

  always #5 clk = ~clk;

  // Observer of the presentation side, sampled on the falling edge.
  logic [2*OP_W-1:0] starts[$];
  logic [2*OP_W-1:0] prev_ops = '0;
  logic prev_en = 1'b0;
  logic prev_pd = 1'b0;
  int run_cur = 0, last_run = 0, gap_cur = 0, last_gap = 0;
  int pd_count = 0, pd_pos = 0, unstable = 0;

  always @(negedge clk) begin
    if (mac_en) begin
      if (!prev_en) last_gap = gap_cur;
      run_cur++;
      if (!prev_en || prev_pd) starts.push_back({op_a, op_b});
      else if ({op_a, op_b} !== prev_ops) unstable++;
      gap_cur = 0;
      if (pair_done) begin
        pd_count++;
        pd_pos = run_cur;
      end
    end else begin
      if (prev_en) last_run = run_cur;
      run_cur = 0;
      gap_cur++;
    end
    prev_en  = mac_en;
    prev_pd  = pair_done;
    prev_ops = {op_a, op_b};
  end

  task automatic chk(input string tag, input logic [2*OP_W-1:0] obs,
                     input logic [2*OP_W-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high; callers drop it when the stream pauses.
  task automatic send_word(input logic [WORD_W-1:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) begin
      fails++;
      $error("FAIL send_word timeout observed=in_ready_low expected=in_ready_high");
    end
    step();
  endtask

  task automatic send_pair(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    for (int i = 0; i < OP_W / WORD_W; i++) send_word(a[i*WORD_W +: WORD_W]);
    for (int i = 0; i < OP_W / WORD_W; i++) send_word(b[i*WORD_W +: WORD_W]);
  endtask

  task automatic wait_run_end();
    int n = 0;
    while (!mac_en && n < 20) begin
      step();
      n++;
    end
    n = 0;
    while (mac_en && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000 || !(n > 0 || !mac_en)) begin
      fails++;
      $error("FAIL wait_run_end timeout observed=mac_en_high expected=mac_en_low");
    end
    step();
  endtask

  logic [OP_W-1:0] a3, b3;
  int pd_before;
  logic pd_prev;

  initial begin
    a3 = 256'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_01234567_89abcdef_fedcba98_76543210;
    b3 = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset state
    #12;
    chk("rst_mac_en", mac_en, 0);
    chk("rst_pair_done", pair_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pairs_done", pairs_done, 0);
    chk("rst_op_a", op_a, 0);
    #11 rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    // 1. Single pair
    pd_before = pd_count;
    send_pair(256'd1, 256'd2);
    in_valid = 1'b0;
    chk("t1_latency_low", mac_en, 0);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_mac_en_rise", mac_en, 1);
    chk("t1_ops", {op_a, op_b}, {256'd1, 256'd2});
    wait_run_end();
    chk("t1_run_len", last_run, PERIOD);
    chk("t1_pd_count", pd_count - pd_before, 1);
    chk("t1_pd_pos", pd_pos, PERIOD);
    chk("t1_pairs_done", pairs_done, 1);
    chk("t1_mac_en_low", mac_en, 0);
    chk("t1_unstable", unstable, 0);

    // 2. Back-to-back
    starts.delete();
    pd_before = pd_count;
    send_pair(256'd3, 256'd5);
    send_pair(256'd7, 256'd11);
    in_valid = 1'b0;
    wait_run_end();
    chk("t2_run_len", last_run, 2 * PERIOD);
    chk("t2_nstarts", starts.size(), 2);
    chk("t2_p0_ops", starts[0], {256'd3, 256'd5});
    chk("t2_p1_ops", starts[1], {256'd7, 256'd11});
    chk("t2_pd_count", pd_count - pd_before, 2);
    chk("t2_pd_pos", pd_pos, 2 * PERIOD);
    chk("t2_pairs_done", pairs_done, 3);
    chk("t2_unstable", unstable, 0);

    // 3. Backpressure with in_valid held high
    starts.delete();
    send_pair(256'h21, 256'h22);
    send_pair(256'h31, 256'h32);
    chk("t3_ready_low", in_ready, 0);
    in_data = a3[WORD_W-1:0];
    pd_prev = 1'b0;
    for (int n = 0; n < 1000 && !in_ready; n++) begin
      pd_prev = pair_done;
      step();
    end
    chk("t3_ready_after_done", pd_prev, 1);
    send_pair(a3, b3);
    in_valid = 1'b0;
    wait_run_end();
    chk("t3_run_len", last_run, 3 * PERIOD);
    chk("t3_nstarts", starts.size(), 3);
    chk("t3_p0_ops", starts[0], {256'h21, 256'h22});
    chk("t3_p1_ops", starts[1], {256'h31, 256'h32});
    chk("t3_p2_ops", starts[2], {a3, b3});
    chk("t3_pairs_done", pairs_done, 6);

    // 4. Bubble: P1 completes on the edge that releases P0
    starts.delete();
    send_pair(256'hA, 256'hB);
    in_valid = 1'b0;
    for (int n = 0; n < 244; n++) step();
    send_pair(256'hC, 256'hD);
    in_valid = 1'b0;
    wait_run_end();
    chk("t4_gap", last_gap, 1);
    chk("t4_run_len", last_run, PERIOD);
    chk("t4_nstarts", starts.size(), 2);
    chk("t4_p1_ops", starts[1], {256'hC, 256'hD});
    chk("t4_pairs_done", pairs_done, 8);

    // 5. clear mid-pair; the word offered in the clear cycle is dropped
    starts.delete();
    for (int i = 0; i < 5; i++) send_word(32'hDEAD_0000 + 32'(i));
    chk("t5_busy_partial", busy, 1);
    in_data = 32'hBAD0_BAD0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("t5_busy_cleared", busy, 0);
    chk("t5_pairs_kept", pairs_done, 8);
    send_pair(256'd9, 256'd4);
    in_valid = 1'b0;
    wait_run_end();
    chk("t5_ops", starts[0], {256'd9, 256'd4});
    chk("t5_pairs_done", pairs_done, 9);

    // clear during RUN stops presentation on the next cycle
    send_pair(256'h44, 256'h45);
    in_valid = 1'b0;
    for (int n = 0; n < 10; n++) step();
    chk("t5r_running", mac_en, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t5r_mac_en", mac_en, 0);
    chk("t5r_pair_done", pair_done, 0);
    chk("t5r_busy", busy, 0);
    step();
    chk("t5r_stays_idle", mac_en, 0);
    chk("t5r_pairs_kept", pairs_done, 9);

    // 6. Asynchronous reset during RUN
    send_pair(256'h55, 256'h66);
    in_valid = 1'b0;
    for (int n = 0; n < 101; n++) step();
    chk("t6_running", mac_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_mac_en", mac_en, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_pairs", pairs_done, 0);
    #2 rst_n = 1'b1;
    step();
    chk("t6_in_ready", in_ready, 1);
    chk("t6_mac_en", mac_en, 0);
    chk("t6_busy", busy, 0);
    starts.delete();
    send_pair(256'h77, 256'h33);
    in_valid = 1'b0;
    wait_run_end();
    chk("t6_after_ops", starts[0], {256'h77, 256'h33});
    chk("t6_after_pairs", pairs_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
